// File: rtl/avmm_lvds_bridge_pkg.sv
// Shared definitions for the AVMM-LVDS bridge packet protocol model:
// header layout, command encodings, FSM states and header helpers.
package avmm_lvds_bridge_pkg;

  localparam int MAX_BURST   = 16;
  localparam int HDR_CMD_HI  = 31;
  localparam int HDR_CMD_LO  = 30;
  localparam int HDR_ERR_BIT = 29;
  localparam int HDR_BC_HI   = 7;
  localparam int HDR_BC_LO   = 0;

  typedef enum logic [1:0] {
    CMD_WRITE = 2'b01,
    CMD_READ  = 2'b10
  } cmd_t;

  typedef enum logic {
    NOBURST,
    BURST
  } pkt_type_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_ADDR,
    S_WDATA,
    S_WRESP,
    S_RESP_HDR,
    S_RDATA
  } mstate_t;

  // cmd is kept raw: illegal encodings must survive decode to be echoed back
  typedef struct packed {
    logic [1:0] cmd;
    logic [7:0] bc;
  } req_hdr_t;

  function automatic logic [31:0] pack_req_hdr(input logic [1:0] cmd, input logic [7:0] bc);
    logic [31:0] w;
    w = '0;
    w[HDR_CMD_HI:HDR_CMD_LO] = cmd;
    w[HDR_BC_HI:HDR_BC_LO]   = bc;
    return w;
  endfunction

  function automatic logic [31:0] pack_resp_hdr(input logic [1:0] cmd, input logic err,
                                                input logic [7:0] bc);
    logic [31:0] w;
    w = '0;
    w[HDR_CMD_HI:HDR_CMD_LO] = cmd;
    w[HDR_ERR_BIT]           = err;
    w[HDR_BC_HI:HDR_BC_LO]   = bc;
    return w;
  endfunction

  function automatic req_hdr_t unpack_req_hdr(input logic [31:0] w);
    req_hdr_t h;
    h.cmd = w[HDR_CMD_HI:HDR_CMD_LO];
    h.bc  = w[HDR_BC_HI:HDR_BC_LO];
    return h;
  endfunction

  function automatic logic hdr_bad(input req_hdr_t h, input logic [31:0] max_burst);
    return ((h.cmd != CMD_WRITE) && (h.cmd != CMD_READ)) ||
           (h.bc == 8'd0) || ({24'd0, h.bc} > max_burst);
  endfunction

endpackage

// File: rtl/avalon_master_stub_if.sv
// Request (FIFO read side) and response (FIFO write side) channels of the
// master stub; names follow the master's point of view.
interface avalon_master_stub_if #(
  parameter int MAX_BURST = avmm_lvds_bridge_pkg::MAX_BURST
);
  localparam int UW = $clog2(MAX_BURST) + 1;

  logic          req_rdreq_o;
  logic [31:0]   req_q_i;
  logic          req_rdempty_i;
  logic [UW-1:0] req_rdusedw_i;
  logic [31:0]   resp_data_o;
  logic          resp_valid_o;

  modport master (
    output req_rdreq_o, resp_data_o, resp_valid_o,
    input  req_q_i, req_rdempty_i, req_rdusedw_i
  );

  modport slave (
    input  req_rdreq_o, resp_data_o, resp_valid_o,
    output req_q_i, req_rdempty_i, req_rdusedw_i
  );
endinterface

// File: rtl/avalon_master_stub_mem.sv
// Single-port word memory with one-cycle registered read; contents are
// deliberately not reset so they survive a controller reset.
module stub_mem #(
  parameter int MEM_WORDS = 1024,
  localparam int AW = $clog2(MEM_WORDS)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);
  logic [31:0] mem_q [MEM_WORDS];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
    rdata_o <= mem_q[addr_i];
  end
endmodule

// File: rtl/avalon_master_stub.sv
// Behavioural Avalon-MM master endpoint: pops request packets, executes them
// against a local word memory and pushes response packets.
module avalon_master_stub #(
  parameter int MAX_BURST = avmm_lvds_bridge_pkg::MAX_BURST,
  parameter int MEM_WORDS = 1024
) (
  input logic clk_i,
  input logic rst_i,
  avalon_master_stub_if.master bus
);
  import avmm_lvds_bridge_pkg::*;

  localparam int AW = $clog2(MEM_WORDS);

  mstate_t       state_q, state_d;
  logic          pend_q, pend_d;
  logic [1:0]    cmd_q, cmd_d;
  logic [7:0]    bc_q, bc_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [AW-1:0] addr_q, addr_d;

  logic          rdreq;
  logic          push;
  logic [31:0]   push_data;
  logic          mem_we;
  logic [31:0]   mem_rdata;
  req_hdr_t      hdr;
  logic          unused_usedw;

  assign hdr          = unpack_req_hdr(bus.req_q_i);
  assign unused_usedw = ^bus.req_rdusedw_i;

  stub_mem #(.MEM_WORDS(MEM_WORDS)) u_mem (
    .clk_i   (clk_i),
    .we_i    (mem_we),
    .addr_i  (addr_q),
    .wdata_i (bus.req_q_i),
    .rdata_o (mem_rdata)
  );

  // pend_q marks a word popped last cycle; req_q_i holds it now and it is
  // consumed this cycle. Pops are only issued for words the packet still owes.
  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    bc_d      = bc_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    rdreq     = 1'b0;
    push      = 1'b0;
    push_data = '0;
    mem_we    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!bus.req_rdempty_i) begin
          rdreq   = 1'b1;
          state_d = S_HDR;
        end
      end
      S_HDR: begin
        if (hdr_bad(hdr, 32'(MAX_BURST))) begin
          push      = 1'b1;
          push_data = pack_resp_hdr(hdr.cmd, 1'b1, hdr.bc);
          state_d   = S_IDLE;
        end else begin
          cmd_d   = hdr.cmd;
          bc_d    = hdr.bc;
          cnt_d   = hdr.bc;
          rdreq   = !bus.req_rdempty_i;
          state_d = S_ADDR;
        end
      end
      S_ADDR: begin
        if (pend_q) begin
          addr_d = bus.req_q_i[AW-1:0];
          if (cmd_q == CMD_WRITE) begin
            rdreq   = !bus.req_rdempty_i;
            state_d = S_WDATA;
          end else begin
            state_d = S_RESP_HDR;
          end
        end else begin
          rdreq = !bus.req_rdempty_i;
        end
      end
      S_WDATA: begin
        if (pend_q) begin
          mem_we = 1'b1;
          addr_d = addr_q + AW'(1);
          cnt_d  = cnt_q - 8'd1;
          if (cnt_q == 8'd1) state_d = S_WRESP;
          else               rdreq   = !bus.req_rdempty_i;
        end else begin
          rdreq = !bus.req_rdempty_i;
        end
      end
      S_WRESP: begin
        push      = 1'b1;
        push_data = pack_resp_hdr(cmd_q, 1'b0, bc_q);
        state_d   = S_IDLE;
      end
      S_RESP_HDR: begin
        push      = 1'b1;
        push_data = pack_resp_hdr(cmd_q, 1'b0, bc_q);
        addr_d    = addr_q + AW'(1);
        state_d   = S_RDATA;
      end
      S_RDATA: begin
        push      = 1'b1;
        push_data = mem_rdata;
        addr_d    = addr_q + AW'(1);
        cnt_d     = cnt_q - 8'd1;
        if (cnt_q == 8'd1) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // reset overrides in the same cycle, so a pop or push never escapes it
    if (rst_i) begin
      rdreq     = 1'b0;
      push      = 1'b0;
      push_data = '0;
      mem_we    = 1'b0;
    end
    pend_d = rdreq;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      pend_q  <= 1'b0;
      cmd_q   <= '0;
      bc_q    <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      cmd_q   <= cmd_d;
      bc_q    <= bc_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
    end
  end

  assign bus.req_rdreq_o  = rdreq;
  assign bus.resp_valid_o = push;
  assign bus.resp_data_o  = push_data;

endmodule

// File: tb/tb_avalon_master_stub.sv
// Directed bench for avalon_master_stub: behavioural request FIFO, response
// capture queue and a reference word memory for read-back expectations.
module tb_avalon_master_stub;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  avalon_master_stub_if #(.MAX_BURST(16)) bus ();

  avalon_master_stub #(.MAX_BURST(16), .MEM_WORDS(1024)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  logic [31:0] fifo [$];
  logic [31:0] rx_q [$];
  int          rx_t [$];
  bit          gap;
  bit          gap_mode;
  bit          pop_s;
  int          cyc;
  int          viol_empty;
  int          viol_pop;
  int          checks;
  int          errors;
  int          last_t;
  logic [31:0] model [1024];
  bit          written [1024];
  logic [31:0] wbuf [16];

  // Request FIFO: pop decided by rdreq seen before the edge, data appears after it
  initial begin
    bus.req_q_i       = '0;
    bus.req_rdempty_i = 1'b1;
    bus.req_rdusedw_i = '0;
    cyc      = 0;
    viol_pop = 0;
    forever begin
      @(posedge clk);
      cyc++;
      #2;
      if (pop_s) begin
        if (fifo.size() > 0) bus.req_q_i = fifo.pop_front();
        else begin
          bus.req_q_i = 'x;
          viol_pop++;
        end
      end
      bus.req_rdempty_i = (fifo.size() == 0) || gap;
      bus.req_rdusedw_i = 5'((fifo.size() > 16) ? 16 : fifo.size());
    end
  end

  initial begin
    viol_empty = 0;
    forever begin
      @(negedge clk);
      pop_s = bus.req_rdreq_o;
      if (bus.req_rdreq_o && bus.req_rdempty_i) viol_empty++;
      if (bus.resp_valid_o) begin
        rx_q.push_back(bus.resp_data_o);
        rx_t.push_back(cyc);
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached (checks %0d)", checks);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_word(input logic [31:0] w);
    if (gap_mode) begin
      gap = 1'b1;
      repeat ($urandom_range(0, 5)) tick();
      gap = 1'b0;
    end
    fifo.push_back(w);
  endtask

  task automatic expect_word(input string tag, input logic [31:0] exp);
    int n;
    logic [31:0] obs;
    n = 0;
    while (rx_q.size() == 0 && n < 300) begin
      tick();
      n++;
    end
    obs = 'x;
    if (rx_q.size() > 0) begin
      obs    = rx_q.pop_front();
      last_t = rx_t.pop_front();
    end
    check(tag, obs, exp);
  endtask

  task automatic do_write(input int addr, input int n, input string tag);
    push_word({2'b01, 22'd0, 8'(n)});
    push_word(32'(addr));
    for (int i = 0; i < n; i++) begin
      push_word(wbuf[i]);
      model[(addr + i) % 1024]   = wbuf[i];
      written[(addr + i) % 1024] = 1'b1;
    end
    expect_word({tag, "_hdr"}, {2'b01, 22'd0, 8'(n)});
  endtask

  task automatic do_read(input int addr, input int n, input string tag);
    int t0;
    push_word({2'b10, 22'd0, 8'(n)});
    push_word(32'(addr));
    expect_word({tag, "_hdr"}, {2'b10, 22'd0, 8'(n)});
    t0 = last_t;
    for (int i = 0; i < n; i++)
      expect_word($sformatf("%s_d%0d", tag, i), model[(addr + i) % 1024]);
    check({tag, "_gapless"}, 32'(last_t - t0), 32'(n));
  endtask

  initial begin
    int n;
    int a;
    checks   = 0;
    errors   = 0;
    gap      = 1'b0;
    gap_mode = 1'b0;
    last_t   = 0;
    rst      = 1'b1;
    for (int i = 0; i < 1024; i++) written[i] = 1'b0;

    // reset state
    repeat (3) tick();
    @(negedge clk);
    check("rst_rdreq", 32'(bus.req_rdreq_o), 32'd0);
    check("rst_valid", 32'(bus.resp_valid_o), 32'd0);
    check("rst_data", bus.resp_data_o, 32'd0);
    tick();
    rst = 1'b0;
    repeat (4) tick();
    @(negedge clk);
    check("idle_rdreq", 32'(bus.req_rdreq_o), 32'd0);
    check("idle_rx", 32'(rx_q.size()), 32'd0);
    tick();

    // single write then read
    push_word(32'h4000_0001); push_word(32'h0000_0005); push_word(32'hDEAD_BEEF);
    expect_word("w1_hdr", 32'h4000_0001);
    push_word(32'h8000_0001); push_word(32'h0000_0005);
    expect_word("r1_hdr", 32'h8000_0001);
    expect_word("r1_d0", 32'hDEAD_BEEF);
    model[5] = 32'hDEAD_BEEF; written[5] = 1'b1;

    // burst crossing the top of memory
    push_word(32'h4000_0004); push_word(32'd1022);
    push_word(32'd1); push_word(32'd2); push_word(32'd3); push_word(32'd4);
    expect_word("wrap_w_hdr", 32'h4000_0004);
    push_word(32'h8000_0004); push_word(32'd1022);
    expect_word("wrap_r_hdr", 32'h8000_0004);
    expect_word("wrap_r_d0", 32'd1);
    expect_word("wrap_r_d1", 32'd2);
    expect_word("wrap_r_d2", 32'd3);
    expect_word("wrap_r_d3", 32'd4);
    push_word(32'h8000_0002); push_word(32'd0);
    expect_word("wrap_m0_hdr", 32'h8000_0002);
    expect_word("wrap_mem0", 32'd3);
    expect_word("wrap_mem1", 32'd4);
    model[1022] = 32'd1; model[1023] = 32'd2; model[0] = 32'd3; model[1] = 32'd4;
    written[1022] = 1'b1; written[1023] = 1'b1; written[0] = 1'b1; written[1] = 1'b1;

    // header errors; a following READ proves nothing extra was consumed
    push_word(32'hC000_0001);
    push_word(32'h8000_0001); push_word(32'h0000_0005);
    expect_word("err_cmd11", 32'hE000_0001);
    expect_word("err_next_hdr", 32'h8000_0001);
    expect_word("err_next_d0", 32'hDEAD_BEEF);
    push_word(32'h8000_0000);
    expect_word("err_bc0", 32'hA000_0000);
    push_word(32'h4000_0011);
    expect_word("err_bc17", 32'h6000_0011);
    push_word(32'h0000_0001);
    expect_word("err_cmd00", 32'h2000_0001);
    repeat (6) tick();
    check("err_no_extra_rx", 32'(rx_q.size()), 32'd0);
    check("err_fifo_drained", 32'(fifo.size()), 32'd0);

    // gappy request FIFO, maximum burst
    gap_mode = 1'b1;
    for (int i = 0; i < 16; i++) wbuf[i] = $urandom;
    do_write(300, 16, "gap_w");
    do_read(300, 16, "gap_r");
    gap_mode = 1'b0;

    // reset during word 3 of an 8-word read response
    for (int i = 0; i < 8; i++) wbuf[i] = 32'h1000_0000 + 32'(i);
    do_write(100, 8, "mr_w");
    push_word(32'h8000_0008); push_word(32'd100);
    n = 0;
    while (rx_q.size() < 3 && n < 300) begin
      tick();
      n++;
    end
    rst = 1'b1;
    @(negedge clk);
    check("mr_gated_valid", 32'(bus.resp_valid_o), 32'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("mr_next_valid", 32'(bus.resp_valid_o), 32'd0);
    tick();
    check("mr_rx_count", 32'(rx_q.size()), 32'd3);
    expect_word("mr_hdr", 32'h8000_0008);
    expect_word("mr_d0", 32'h1000_0000);
    expect_word("mr_d1", 32'h1000_0001);
    do_read(100, 8, "mr_r");

    // reset held while the FIFO has data: no pop may be issued
    rst = 1'b1;
    push_word(32'h8000_0001); push_word(32'h0000_0005);
    tick();
    @(negedge clk);
    check("rp_rdreq", 32'(bus.req_rdreq_o), 32'd0);
    tick();
    check("rp_fifo", 32'(fifo.size()), 32'd2);
    rst = 1'b0;
    expect_word("rp_hdr", 32'h8000_0001);
    expect_word("rp_d0", 32'hDEAD_BEEF);

    // random regression against the reference memory
    for (int k = 0; k < 1000; k++) begin
      a = $urandom_range(0, 1023);
      if (written[a] && ($urandom_range(0, 1) == 1)) do_read(a, 1, "rs_r");
      else begin
        wbuf[0] = $urandom;
        do_write(a, 1, "rs_w");
      end
    end
    for (int k = 0; k < 100; k++) begin
      n = $urandom_range(2, 16);
      a = $urandom_range(0, 1023);
      for (int i = 0; i < 16; i++) wbuf[i] = $urandom;
      do_write(a, n, "rb_w");
      do_read(a, n, "rb_r");
    end

    repeat (4) tick();
    check("no_pop_when_empty", 32'(viol_empty), 32'd0);
    check("no_pop_underflow", 32'(viol_pop), 32'd0);
    check("final_rx_empty", 32'(rx_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
